// File: rtl/symbol_feeder.sv
// Symbol FIFO feeding a downstream sequence detector: circular buffer with registered pop output.
// Optional occupancy output enabled by defining SYMBOL_FEEDER_LEVEL_EN.
module symbol_feeder #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    in_sym,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          run,
  output logic [1:0]    num,
  output logic          num_valid,
  output logic          overflow
`ifdef SYMBOL_FEEDER_LEVEL_EN
  ,
  output logic [LW-1:0] level
`endif
);

  localparam int PW = LW - 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [1:0]    num_q, num_d;
  logic          num_valid_q, num_valid_d;
  logic          overflow_q, overflow_d;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  // Handshake decode; full blocks a push even when a pop frees a slot on the same edge.
  always_comb begin
    full_s = (count_q == FULL_CNT);
    push_s = in_valid && !full_s;
    pop_s  = run && (count_q != {LW{1'b0}});
  end

  // Next-state for pointers, occupancy, output stage and sticky overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, pop_s};
    num_d       = 2'b00;
    num_valid_d = 1'b0;
    overflow_d  = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // Idle cycles emit 00 so the detector falls back to its start state.
    if (pop_s) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      num_d       = mem_q[rd_ptr_q];
      num_valid_d = 1'b1;
    end else begin
      rd_ptr_d    = rd_ptr_q;
      num_d       = 2'b00;
      num_valid_d = 1'b0;
    end
    if (in_valid && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers; reset wins over push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {LW{1'b0}};
      num_q       <= 2'b00;
      num_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Symbol storage; contents are not cleared by reset since the pointers discard them.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_q[wr_ptr_q] <= in_sym;
    end
  end

  assign in_ready  = !full_s;
  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign overflow  = overflow_q;
`ifdef SYMBOL_FEEDER_LEVEL_EN
  assign level     = count_q;
`endif

endmodule

// File: tb/tb_symbol_feeder.sv
// Self-checking bench for symbol_feeder: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_symbol_feeder;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    in_sym;
  logic          in_valid;
  logic          in_ready;
  logic          run;
  logic [1:0]    num;
  logic          num_valid;
  logic          overflow;
`ifdef SYMBOL_FEEDER_LEVEL_EN
  logic [LW-1:0] level;
`endif

  symbol_feeder #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_sym   (in_sym),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .run      (run),
    .num      (num),
    .num_valid(num_valid),
    .overflow (overflow)
`ifdef SYMBOL_FEEDER_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: a queue of pending symbols plus the registered output stage.
  logic [1:0] q[$];
  logic [1:0] m_num;
  logic       m_nv;
  logic       m_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_num = 2'b00;
      m_nv  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = run && (q.size() > 0);
      do_push = in_valid && (q.size() < DEPTH);
      if (in_valid && q.size() == DEPTH) m_ovf = 1'b1;
      if (do_pop) begin
        m_num = q.pop_front();
        m_nv  = 1'b1;
      end else begin
        m_num = 2'b00;
        m_nv  = 1'b0;
      end
      if (do_push) q.push_back(in_sym);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_num", {6'd0, num}, {6'd0, m_num});
      chk("model_num_valid", {7'd0, num_valid}, {7'd0, m_nv});
      chk("model_in_ready", {7'd0, in_ready}, {7'd0, (q.size() != DEPTH)});
      chk("model_overflow", {7'd0, overflow}, {7'd0, m_ovf});
`ifdef SYMBOL_FEEDER_LEVEL_EN
      chk("model_level", {5'd0, level}, 8'(q.size()));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic r);
    in_valid = v;
    in_sym   = s;
    run      = r;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sym = 2'b00; run = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_num", {6'd0, num}, 8'h00);
    chk("reset_num_valid", {7'd0, num_valid}, 8'h00);
    chk("reset_in_ready", {7'd0, in_ready}, 8'h01);
    chk("reset_overflow", {7'd0, overflow}, 8'h00);

    // Three symbols streamed back to back with one cycle of latency.
    drive(1'b1, 2'b01, 1'b1);
    chk("lat_first_nv", {7'd0, num_valid}, 8'h00);
    drive(1'b1, 2'b10, 1'b1);
    chk("stream_0", {6'd0, num}, 8'h01);
    drive(1'b1, 2'b11, 1'b1);
    chk("stream_1", {6'd0, num}, 8'h02);
    drive(1'b0, 2'b00, 1'b1);
    chk("stream_2", {6'd0, num}, 8'h03);
    drive(1'b0, 2'b00, 1'b1);
    chk("stream_idle_nv", {7'd0, num_valid}, 8'h00);

    // Fill with run low, then one extra attempt to trip overflow.
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    chk("fill3_ready", {7'd0, in_ready}, 8'h01);
    drive(1'b1, 2'b01, 1'b0);
    chk("full_ready", {7'd0, in_ready}, 8'h00);
    chk("full_no_ovf", {7'd0, overflow}, 8'h00);
`ifdef SYMBOL_FEEDER_LEVEL_EN
    chk("full_level", {5'd0, level}, 8'h04);
`endif
    drive(1'b1, 2'b10, 1'b0);
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    chk("ovf_num_valid", {7'd0, num_valid}, 8'h00);

    // From full: first edge pops only, then steady push+pop across the wrap.
    drive(1'b1, 2'b11, 1'b1);
    chk("full_pop_num", {6'd0, num}, 8'h01);
    chk("full_pop_ready", {7'd0, in_ready}, 8'h01);
    drive(1'b1, 2'b00, 1'b1);
    chk("steady_num0", {6'd0, num}, 8'h02);
    drive(1'b1, 2'b01, 1'b1);
    chk("steady_num1", {6'd0, num}, 8'h03);
    drive(1'b1, 2'b10, 1'b1);
    chk("steady_num2", {6'd0, num}, 8'h01);
    drive(1'b1, 2'b11, 1'b1);
    chk("steady_wrap", {6'd0, num}, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 1'b1);
    chk("drained_nv", {7'd0, num_valid}, 8'h00);

    // Gap in the stream emits an idle 00 between symbols.
    drive(1'b1, 2'b01, 1'b1);
    drive(1'b1, 2'b10, 1'b1);
    drive(1'b0, 2'b00, 1'b1);
    chk("gap_pre", {6'd0, num}, 8'h02);
    drive(1'b0, 2'b00, 1'b1);
    chk("gap_idle", {6'd0, num}, 8'h00);
    drive(1'b1, 2'b11, 1'b1);
    drive(1'b0, 2'b00, 1'b1);
    chk("gap_post", {6'd0, num}, 8'h03);

    // Reset with three symbols buffered and run high.
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    in_valid = 1'b1; run = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_mid_num", {6'd0, num}, 8'h00);
    chk("rst_mid_nv", {7'd0, num_valid}, 8'h00);
    chk("rst_mid_ready", {7'd0, in_ready}, 8'h01);
    chk("rst_mid_ovf", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      chk("rst_no_stale", {7'd0, num_valid}, 8'h00);
    end

    // Pseudo-random traffic checked against the model every cycle.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/symbol_feeder.md
SYMBOL_FEEDER -- requirements
Module: symbol_feeder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in symbols; SHALL be a power of two, minimum 2.
REQ-002 Parameter LW, default 3, occupancy width; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 in_sym  input  2  producer symbol: 01 / 10 / 11 valid codes; 00 is carried as data, not filtered.
REQ-006 in_valid  input  1  producer asserts: in_sym is valid this cycle.
REQ-007 in_ready  output  1  feeder can accept a symbol this cycle; combinational, equals !full.
REQ-008 run  input  1  consumer enable; when 0, the feeder SHALL not pop.
REQ-009 num  output  2  registered symbol stream, driven straight into the downstream sequence detector's num input.
REQ-010 num_valid  output  1  registered; 1 when num carries a popped symbol this cycle.
REQ-011 overflow  output  1  sticky flag; set when in_valid=1 while in_ready=0.

Function
REQ-012 Storage SHALL be a circular buffer: DEPTH x 2-bit entries, write pointer, read pointer, occupancy count 0..DEPTH.
REQ-013 Push SHALL occur on a clock edge iff in_valid=1 and in_ready=1; in_sym is written at the write pointer and the pointer advances modulo DEPTH.
REQ-014 Pop SHALL occur on a clock edge iff run=1 and count>0 before the edge; the head entry loads into num, num_valid is set to 1, and the read pointer advances modulo DEPTH.
REQ-015 On any edge with no pop, num SHALL load 2'b00 and num_valid SHALL load 0.
- Idle 00 deliberately returns the downstream detector to its start state.
- A gap in the stream therefore breaks any sequence in progress.
REQ-016 Latency: a symbol pushed at edge N SHALL appear on num no earlier than after edge N+1; there is no bypass path.
REQ-017 Ordering SHALL be strict FIFO; no symbol is dropped or duplicated while in_ready=1.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and both pointers advance.
REQ-019 When count==DEPTH, in_ready SHALL be 0 and no push occurs, even if a pop occurs on the same edge.
REQ-020 When count==0, no pop occurs regardless of run.
REQ-021 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no bubble.
REQ-022 overflow SHALL set on an edge where in_valid=1 and in_ready=0, and hold until reset.
REQ-023 Count SHALL be computed as count + push - pop in LW bits and SHALL never exceed DEPTH.

Reset
REQ-024 On a posedge with reset=1, the following SHALL clear; reset has priority over push and pop on that edge:
- pointers -> 0
- count -> 0
- num -> 2'b00
- num_valid -> 0
- overflow -> 0
REQ-025 Reset mid-stream SHALL discard all buffered symbols; FIFO storage contents need not clear.
REQ-026 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-027 Macro SYMBOL_FEEDER_LEVEL_EN:
- Defined: adds output port level (LW bits), equal to the current occupancy count.
- Undefined: the level port is absent and all other behaviour is identical.

Verification
REQ-028 Reset, then push 01,10,11 on consecutive cycles with run=1 -> num=01,10,11 on three consecutive cycles, the first one cycle after the first push; downstream detector ans=1 thereafter.
REQ-029 run=0, push 5 symbols with in_valid held -> in_ready=0 after 4 accepted; overflow=1 after the 5th attempt; num=00 and num_valid=0 throughout.
REQ-030 From full, set run=1 with in_valid=1 -> first edge: pop only, count=3; then steady push+pop at count=3; order preserved across pointer wrap.
REQ-031 Push 01,10, let the FIFO empty, wait one idle cycle, then push 11 -> num sequence 01,10,00,...,11; downstream ans stays 0.
REQ-032 Assert reset while count=3 and run=1 -> next cycle num=00, num_valid=0, in_ready=1, overflow=0; no stale symbol emitted afterwards.
REQ-033 With SYMBOL_FEEDER_LEVEL_EN defined, run REQ-029 -> level reads 1,2,3,4 and holds at 4.
